// File: rtl/mem_resp_pkg.sv
// Shared definitions for the mem_responder slice: FSM state encoding,
// bus cycle type constants and the physical address width.
package mem_resp_pkg;

  localparam int ADDR_W = 20;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_T1   = 3'd1;
  localparam logic [2:0] ST_T2   = 3'd2;
  localparam logic [2:0] ST_TW   = 3'd3;
  localparam logic [2:0] ST_T3   = 3'd4;
  localparam logic [2:0] ST_T4   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_T1   = ST_T1,
    S_T2   = ST_T2,
    S_TW   = ST_TW,
    S_T3   = ST_T3,
    S_T4   = ST_T4
  } state_t;

  localparam logic CYC_READ  = 1'b0;
  localparam logic CYC_WRITE = 1'b1;

  // True when the upper address bits select this responder's window.
  function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] base,
                                     input int                depth_log2);
    return (addr >> depth_log2) == (base >> depth_log2);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Bus control bundle between the interface I/O buffer (master) and the
// memory responder (slave). The shared 8-bit Data bus is an inout port of
// the responder itself so that tri-state resolution stays on a plain net.
interface mem_responder_if;
  import mem_resp_pkg::*;

  logic              ALE;
  logic [ADDR_W-1:0] Address;
  logic              RD_WR;
  logic              Ready;
  logic              Busy;

  modport master (
    output ALE,
    output Address,
    output RD_WR,
    input  Ready,
    input  Busy
  );

  modport slave (
    input  ALE,
    input  Address,
    input  RD_WR,
    output Ready,
    output Busy
  );

endinterface

// File: rtl/mem_array.sv
// Byte-wide storage for mem_responder: two write ports (bus write has
// priority over the backdoor on an address clash) and an asynchronous read.
// Contents are never reset.
module mem_array #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  bus_we,
  input  logic [DEPTH_LOG2-1:0] bus_addr,
  input  logic [7:0]            bus_wdata,
  input  logic                  load_we,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [7:0]            load_wdata,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [7:0]            rd_data
);

  logic [7:0] mem [2**DEPTH_LOG2];

  // Backdoor write is suppressed when the bus writes the same byte this edge.
  always_ff @(posedge clk) begin
    if (load_we && !(bus_we && (bus_addr == load_addr)))
      mem[load_addr] <= load_wdata;
    if (bus_we)
      mem[bus_addr] <= bus_wdata;
  end

  // Read is combinational, so a same-edge write is seen only next cycle.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the T1..T4 external bus cycle with
// programmable wait states. Reads drive the shared Data bus in T3/T4 only;
// writes capture Data at the end of T3.
// Optional build macro MEM_RESP_ERR_EN adds Err/Err_Count outputs that flag
// ALE seen while a cycle is in progress (T1, T2, TW, T3).
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int                DEPTH_LOG2  = 8,
  parameter logic [ADDR_W-1:0] BASE        = 20'h00000,
  parameter int                WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_responder_if.slave        bus,
  inout  wire  [7:0]            Data,
  input  logic                  Load_EN,
  input  logic [DEPTH_LOG2-1:0] Load_Addr,
  input  logic [7:0]            Load_Data
`ifdef MEM_RESP_ERR_EN
  ,
  output logic                  Err,
  output logic [7:0]            Err_Count
`endif
);

  state_t                state;
  state_t                state_nxt;
  logic [3:0]            wcnt;
  logic [3:0]            wcnt_nxt;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic                  cyc_q;
  logic                  oe_q;
  logic                  start;
  logic                  bus_we;
  logic [7:0]            rd_data;

  // A new cycle may only begin from IDLE or from T4 (back-to-back).
  assign start = bus.ALE && in_window(bus.Address, BASE, DEPTH_LOG2) &&
                 ((state == S_IDLE) || (state == S_T4));

  // State, wait counter, latched address/type and registered drive enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      wcnt   <= '0;
      addr_q <= '0;
      cyc_q  <= CYC_READ;
      oe_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (start) begin
        addr_q <= bus.Address[DEPTH_LOG2-1:0];
        cyc_q  <= bus.RD_WR;
      end
      // Cycle type cannot change between T2 and T4, so cyc_q is stable here.
      oe_q <= ((state_nxt == S_T3) || (state_nxt == S_T4)) && (cyc_q == CYC_READ);
    end
  end

  // Next-state and wait-counter logic for the bus cycle sequence.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      S_IDLE: if (start) state_nxt = S_T1;
      S_T1:   state_nxt = S_T2;
      S_T2: begin
        if (WAIT_STATES > 0) begin
          state_nxt = S_TW;
          wcnt_nxt  = 4'(WAIT_STATES - 1);
        end else begin
          state_nxt = S_T3;
        end
      end
      S_TW: begin
        if (wcnt == 4'd0) state_nxt = S_T3;
        else              wcnt_nxt  = wcnt - 4'd1;
      end
      S_T3:   state_nxt = S_T4;
      S_T4:   state_nxt = start ? S_T1 : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus_we    = (state == S_T3) && (cyc_q == CYC_WRITE);
  assign bus.Ready = !((state == S_T2) || (state == S_TW));
  assign bus.Busy  = (state != S_IDLE);
  assign Data      = oe_q ? rd_data : 8'bz;

  mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem_array (
    .clk        (clk),
    .bus_we     (bus_we),
    .bus_addr   (addr_q),
    .bus_wdata  (Data),
    .load_we    (Load_EN),
    .load_addr  (Load_Addr),
    .load_wdata (Load_Data),
    .rd_addr    (addr_q),
    .rd_data    (rd_data)
  );

`ifdef MEM_RESP_ERR_EN
  logic violation;

  assign violation = bus.ALE && ((state == S_T1) || (state == S_T2) ||
                                 (state == S_TW) || (state == S_T3));

  // One-cycle error pulse and saturating count of protocol violations.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Err       <= 1'b0;
      Err_Count <= 8'h00;
    end else begin
      Err <= violation;
      if (violation && (Err_Count != 8'hFF))
        Err_Count <= Err_Count + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder. Each segment is planned up front as
// a per-cycle timeline (stimulus plus expected Ready/Busy/Data/Err), derived
// from the bus cycle rules: ALE at cycle c occupies c+1..c+4+WS, Ready low for
// c+2..c+2+WS, read data on c+3+WS and c+4+WS. Expected read bytes come from a
// reference byte array updated at the end of each cycle (backdoor, then bus).
// A released Data bus reads 8'hFF through pullups.
module tb_mem_responder;
  import mem_resp_pkg::*;

  localparam int WS = 1;
  localparam int TL = 4 + WS;
  localparam int NC = 600;
  localparam logic [19:0] BASE_ADDR = 20'h00000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tb_oe;
  logic [7:0] tb_data;
  logic       load_en;
  logic [7:0] load_addr;
  logic [7:0] load_data;
  wire  [7:0] data;
`ifdef MEM_RESP_ERR_EN
  logic       err;
  logic [7:0] err_cnt;
`endif

  mem_responder_if bus ();

  assign data = tb_oe ? tb_data : 8'bz;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (data[i]);
  end

  mem_responder #(
    .DEPTH_LOG2 (8),
    .BASE       (BASE_ADDR),
    .WAIT_STATES(WS)
  ) dut (
    .clk       (clk),
    .rst       (rst_n),
    .bus       (bus.slave),
    .Data      (data),
    .Load_EN   (load_en),
    .Load_Addr (load_addr),
    .Load_Data (load_data)
`ifdef MEM_RESP_ERR_EN
    ,
    .Err       (err),
    .Err_Count (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  logic [7:0] ref_mem [256];

  bit         p_ale   [NC];
  logic [19:0] p_addr [NC];
  bit         p_rdwr  [NC];
  bit         p_drv   [NC];
  logic [7:0] p_dval  [NC];
  bit         p_wr    [NC];
  logic [7:0] p_waddr [NC];
  bit         p_rdat  [NC];
  logic [7:0] p_raddr [NC];
  bit         p_ready [NC];
  bit         p_busy  [NC];
  bit         p_ld    [NC];
  logic [7:0] p_ldaddr[NC];
  logic [7:0] p_ldval [NC];
  bit         p_err   [NC];
  bit         p_skip  [NC];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_plan();
    for (int x = 0; x < NC; x++) begin
      p_ale[x] = 0; p_addr[x] = '0; p_rdwr[x] = 0; p_drv[x] = 0; p_dval[x] = '0;
      p_wr[x] = 0; p_waddr[x] = '0; p_rdat[x] = 0; p_raddr[x] = '0;
      p_ready[x] = 1; p_busy[x] = 0; p_ld[x] = 0; p_ldaddr[x] = '0;
      p_ldval[x] = '0; p_err[x] = 0; p_skip[x] = 0;
    end
  endtask

  // Plans one bus cycle with ALE at c; returns the earliest cycle for the next ALE.
  task automatic plan_txn(input int c, input logic [19:0] addr, input bit wr,
                          input logic [7:0] wd, output int nxt);
    p_ale[c] = 1; p_addr[c] = addr; p_rdwr[c] = wr;
    if ((addr >> 8) != (BASE_ADDR >> 8)) begin
      nxt = c + 1;
    end else begin
      for (int k = 1; k <= TL; k++) begin
        p_busy[c+k]  = 1;
        p_ready[c+k] = !(k >= 2 && k <= 2 + WS);
      end
      if (wr) begin
        p_drv[c+3+WS] = 1; p_dval[c+3+WS] = wd;
        p_wr[c+3+WS]  = 1; p_waddr[c+3+WS] = addr[7:0];
      end else begin
        p_rdat[c+3+WS] = 1; p_raddr[c+3+WS] = addr[7:0];
        p_rdat[c+4+WS] = 1; p_raddr[c+4+WS] = addr[7:0];
      end
      nxt = c + TL;
    end
  endtask

  task automatic set_idle();
    bus.ALE = 0; bus.Address = '0; bus.RD_WR = 0;
    tb_oe = 0; tb_data = '0; load_en = 0; load_addr = '0; load_data = '0;
  endtask

  task automatic run_plan(input int ncyc);
    for (int x = 0; x < ncyc; x++) begin
      @(posedge clk); #1;
      bus.ALE = p_ale[x]; bus.Address = p_addr[x]; bus.RD_WR = p_rdwr[x];
      tb_oe = p_drv[x]; tb_data = p_dval[x];
      load_en = p_ld[x]; load_addr = p_ldaddr[x]; load_data = p_ldval[x];
      #1;
      check($sformatf("ready@%0d", x), 32'(bus.Ready), 32'(p_ready[x]));
      check($sformatf("busy@%0d", x), 32'(bus.Busy), 32'(p_busy[x]));
      if (!p_skip[x]) begin
        if (p_rdat[x])
          check($sformatf("rdata@%0d", x), 32'(data), 32'(ref_mem[p_raddr[x]]));
        else if (!p_drv[x])
          check($sformatf("hiz@%0d", x), 32'(data), 32'hFF);
      end
`ifdef MEM_RESP_ERR_EN
      if (p_err[x] && exp_cnt < 255) exp_cnt++;
      check($sformatf("err@%0d", x), 32'(err), 32'(p_err[x]));
      check($sformatf("errcnt@%0d", x), 32'(err_cnt), 32'(exp_cnt));
`endif
      if (p_ld[x]) ref_mem[p_ldaddr[x]] = p_ldval[x];
      if (p_wr[x]) ref_mem[p_waddr[x]] = p_dval[x];
    end
    #1;
    set_idle();
  endtask

  initial begin
    int c;
    int r;
    logic [19:0] a;
    logic [7:0]  la;
    logic [7:0]  old_v;

    rst_n = 0;
    set_idle();
    repeat (3) @(posedge clk);
    #2;
    check("rst_ready", 32'(bus.Ready), 32'h1);
    check("rst_busy", 32'(bus.Busy), 32'h0);
    check("rst_hiz", 32'(data), 32'hFF);
`ifdef MEM_RESP_ERR_EN
    check("rst_err", 32'(err), 32'h0);
    check("rst_errcnt", 32'(err_cnt), 32'h0);
`endif
    @(posedge clk); #1;
    rst_n = 1;

    // Preload every byte through the backdoor.
    clear_plan();
    for (int i = 0; i < 256; i++) begin
      p_ld[i+1] = 1; p_ldaddr[i+1] = 8'(i);
      p_ldval[i+1] = (i == 8'h10) ? 8'hA5 : (i == 8'h30) ? 8'h5A : 8'($urandom_range(0, 254));
    end
    run_plan(260);

    // Directed cycles.
    clear_plan();
    plan_txn(2, 20'h00010, CYC_READ, 8'h00, c);
    plan_txn(9, 20'h00020, CYC_WRITE, 8'h3C, c);
    p_ld[13] = 1; p_ldaddr[13] = 8'h20; p_ldval[13] = 8'h77;
    plan_txn(16, 20'h00020, CYC_READ, 8'h00, c);
    plan_txn(23, 20'h01000, CYC_READ, 8'h00, c);
    plan_txn(25, 20'h00001, CYC_READ, 8'h00, c);
    plan_txn(c, 20'h00002, CYC_READ, 8'h00, c);
    plan_txn(37, 20'h00030, CYC_READ, 8'h00, c);
    p_ld[41] = 1; p_ldaddr[41] = 8'h30; p_ldval[41] = 8'hC3;
    p_skip[42] = 1;
    plan_txn(44, 20'h00040, CYC_READ, 8'h00, c);
    p_ale[46] = 1; p_addr[46] = 20'h00050; p_rdwr[46] = CYC_WRITE;
    p_err[47] = 1;
    run_plan(55);

    // Randomised traffic with backdoor writes sprinkled in.
    clear_plan();
    c = 1;
    while (c < NC - 20) begin
      r = $urandom_range(0, 9);
      if (r < 2) a = {12'($urandom_range(1, 4095)), 8'($urandom_range(0, 255))};
      else       a = {12'h000, 8'($urandom_range(0, 255))};
      plan_txn(c, a, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)), c);
      c += $urandom_range(0, 2);
    end
    for (int x = 1; x < NC - 5; x++) begin
      la = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0 && !(p_rdat[x] && p_raddr[x] == la)) begin
        p_ld[x] = 1; p_ldaddr[x] = la; p_ldval[x] = 8'($urandom_range(0, 254));
      end
    end
    run_plan(NC);

    // Reset during the wait state of a write aborts it.
    old_v = ref_mem[8'h60];
    clear_plan();
    plan_txn(1, 20'h00060, CYC_WRITE, ~old_v, c);
    run_plan(5);
    rst_n = 0;
    #1;
    check("abort_ready", 32'(bus.Ready), 32'h1);
    check("abort_busy", 32'(bus.Busy), 32'h0);
    check("abort_hiz", 32'(data), 32'hFF);
    exp_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1;
    clear_plan();
    plan_txn(1, 20'h00060, CYC_READ, 8'h00, c);
    run_plan(8);
    check("abort_mem_model", 32'(ref_mem[8'h60]), 32'(old_v));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
